// File: rtl/ltssm_pkg.sv
// Shared LTSSM receive-side constants, TS type and state encodings.
// Symbol index constants locate fields inside a 16-symbol TS word.
package ltssm_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] TS1_ID  = 8'h4A;
  localparam logic [7:0] TS2_ID  = 8'h45;
  localparam logic [7:0] PAD_SYM = 8'hF7;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    TS1  = 2'd1,
    TS2  = 2'd2
  } ts_type_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_QUAL  = 2'd2;

  localparam int LINK = 1;
  localparam int LANE = 2;
  localparam int NFTS = 3;
  localparam int RATE = 4;
  localparam int CTRL = 5;

  // body holds symbols 1..15; symbol k sits at bits [8(k-1)+7:8(k-1)]
  function automatic logic [7:0] sym_of(
    input logic [119:0] body,
    input int           k
  );
    return body[8*(k-1) +: 8];
  endfunction

endpackage

// File: rtl/ts_decode.sv
// Combinational TS word decoder: framing check, TS1/TS2 type, body.
// Ports: ts_i (128b word) -> well_formed, ts_type, body (symbols 1..15).
module ts_decode
  import ltssm_pkg::*;
(
  input  logic [127:0] ts_i,
  output logic         well_formed,
  output ts_type_t     ts_type,
  output logic [119:0] body
);

  logic all_ts1;
  logic all_ts2;

  always_comb begin
    all_ts1 = 1'b1;
    all_ts2 = 1'b1;
    for (int k = 6; k < 16; k++) begin
      all_ts1 &= (ts_i[8*k +: 8] == TS1_ID);
      all_ts2 &= (ts_i[8*k +: 8] == TS2_ID);
    end
  end

  always_comb begin
    ts_type = NONE;
    unique case (1'b1)
      all_ts1: ts_type = TS1;
      all_ts2: ts_type = TS2;
      default: ts_type = NONE;
    endcase
  end

  assign body = ts_i[127:8];

  assign well_formed = (ts_i[7:0] == COM_SYM)
                     && (all_ts1 || all_ts2);

endmodule

// File: rtl/ts_rx_qualifier.sv
// Per-lane TS receive qualifier: counts consecutive identical TS1/TS2.
// Ports: ts_i/ts_i_vld/clr in; type, count, qual flags, fields, err out.
module ts_rx_qualifier
  import ltssm_pkg::*;
#(
  parameter int MATCH_CNT = 8,
  parameter int GAP_MAX   = 64,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     ts_i,
  input  logic             ts_i_vld,
  input  logic             clr,
  output logic [1:0]       ts_type,
  output logic [CNT_W-1:0] ts_cnt,
  output logic             ts1_qual,
  output logic             ts2_qual,
  output logic [7:0]       rx_link_num,
  output logic [7:0]       rx_lane_num,
  output logic [7:0]       rx_ctrl,
  output logic             link_pad,
  output logic             lane_pad,
  output logic             ts_err
);

  localparam int GAP_W = $clog2(GAP_MAX + 1);
  localparam logic [CNT_W-1:0] MATCH_V =
    CNT_W'(MATCH_CNT);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'(GAP_MAX - 1);

  logic         dec_wf;
  ts_type_t     dec_type;
  logic [119:0] dec_body;

  ts_decode u_dec (
    .ts_i        (ts_i),
    .well_formed (dec_wf),
    .ts_type     (dec_type),
    .body        (dec_body)
  );

  logic [1:0]       state_q, state_d;
  logic [119:0]     ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  ts_type_t         type_q, type_d;
  logic             q1_q, q1_d;
  logic             q2_q, q2_d;
  logic             lpad_q, lpad_d;
  logic             npad_q, npad_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    type_d  = type_q;
    err_d   = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      ref_d   = '0;
      cnt_d   = '0;
      gap_d   = '0;
      type_d  = NONE;
    end else if (ts_i_vld) begin
      gap_d = '0;
      if (!dec_wf) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
        ref_d   = '0;
        cnt_d   = '0;
        type_d  = NONE;
      end else begin
        // a new run starts on the first word or any body change
        if (state_q == ST_IDLE || dec_body != ref_q) begin
          ref_d  = dec_body;
          cnt_d  = CNT_W'(1);
          type_d = dec_type;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = (cnt_d >= MATCH_V) ? ST_QUAL : ST_ACCUM;
      end
    end else if (state_q != ST_IDLE) begin
      if (gap_q == GAP_LAST) begin
        state_d = ST_IDLE;
        ref_d   = '0;
        cnt_d   = '0;
        gap_d   = '0;
        type_d  = NONE;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
    q1_d   = (state_d == ST_QUAL) && (type_d == TS1);
    q2_d   = (state_d == ST_QUAL) && (type_d == TS2);
    lpad_d = sym_of(ref_d, LINK) == PAD_SYM;
    npad_d = sym_of(ref_d, LANE) == PAD_SYM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ref_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      type_q  <= NONE;
      q1_q    <= 1'b0;
      q2_q    <= 1'b0;
      lpad_q  <= 1'b0;
      npad_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      type_q  <= type_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      lpad_q  <= lpad_d;
      npad_q  <= npad_d;
      err_q   <= err_d;
    end
  end

  assign ts_type     = type_q;
  assign ts_cnt      = cnt_q;
  assign ts1_qual    = q1_q;
  assign ts2_qual    = q2_q;
  assign rx_link_num = sym_of(ref_q, LINK);
  assign rx_lane_num = sym_of(ref_q, LANE);
  assign rx_ctrl     = sym_of(ref_q, CTRL);
  assign link_pad    = lpad_q;
  assign lane_pad    = npad_q;
  assign ts_err      = err_q;

endmodule

// File: tb/tb_ts_rx_qualifier.sv
// Scoreboard bench for ts_rx_qualifier: directed TS sequences.
// Expected outputs queued per cycle, compared by a negedge monitor.
module tb_ts_rx_qualifier;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ts_i;
  logic         ts_i_vld;
  logic         clr;
  logic [1:0]   ts_type;
  logic [3:0]   ts_cnt;
  logic         ts1_qual;
  logic         ts2_qual;
  logic [7:0]   rx_link_num;
  logic [7:0]   rx_lane_num;
  logic [7:0]   rx_ctrl;
  logic         link_pad;
  logic         lane_pad;
  logic         ts_err;

  always #5 clk = ~clk;

  ts_rx_qualifier #(
    .MATCH_CNT (8),
    .GAP_MAX   (64),
    .CNT_W     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ts_i        (ts_i),
    .ts_i_vld    (ts_i_vld),
    .clr         (clr),
    .ts_type     (ts_type),
    .ts_cnt      (ts_cnt),
    .ts1_qual    (ts1_qual),
    .ts2_qual    (ts2_qual),
    .rx_link_num (rx_link_num),
    .rx_lane_num (rx_lane_num),
    .rx_ctrl     (rx_ctrl),
    .link_pad    (link_pad),
    .lane_pad    (lane_pad),
    .ts_err      (ts_err)
  );

  typedef struct {
    string      name;
    logic [3:0] cnt;
    logic [1:0] typ;
    logic       q1;
    logic       q2;
    logic [7:0] link;
    logic [7:0] lane;
    logic [7:0] ctrl;
    logic       lp;
    logic       np;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [127:0] mk(
    input logic [7:0] id,
    input logic [7:0] link,
    input logic [7:0] lane,
    input logic [7:0] ctrl
  );
    logic [127:0] w;
    w[7:0]   = 8'hBC;
    w[15:8]  = link;
    w[23:16] = lane;
    w[31:24] = 8'h10;
    w[39:32] = 8'h02;
    w[47:40] = ctrl;
    for (int k = 6; k < 16; k++) w[8*k +: 8] = id;
    return w;
  endfunction

  function automatic exp_t ex(
    input string      n,
    input int         cnt,
    input int         typ,
    input bit         q,
    input logic [7:0] link,
    input logic [7:0] lane,
    input logic [7:0] ctrl,
    input bit         err
  );
    exp_t e;
    e.name = n;
    e.cnt  = 4'(cnt);
    e.typ  = 2'(typ);
    e.q1   = q && typ == 1;
    e.q2   = q && typ == 2;
    e.link = link;
    e.lane = lane;
    e.ctrl = ctrl;
    e.lp   = link == 8'hF7;
    e.np   = lane == 8'hF7;
    e.err  = err;
    return e;
  endfunction

  function automatic exp_t z(input string n);
    return ex(n, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
  endfunction

  function automatic logic [46:0] act();
    return {ts_cnt, ts_type, ts1_qual, ts2_qual,
            rx_link_num, rx_lane_num, rx_ctrl,
            link_pad, lane_pad, ts_err};
  endfunction

  function automatic logic [46:0] pack(input exp_t e);
    return {e.cnt, e.typ, e.q1, e.q2,
            e.link, e.lane, e.ctrl,
            e.lp, e.np, e.err};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (act() !== pack(e)) begin
        errors++;
        $display("FAIL %s: got %h want %h (cnt=%0d typ=%0d want cnt=%0d typ=%0d)",
                 e.name, act(), pack(e), ts_cnt, ts_type,
                 e.cnt, e.typ);
      end
    end
  end

  task automatic chk_now(input string n);
    checks++;
    if (act() !== pack(z(n))) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act(),
               pack(z(n)));
    end
  endtask

  task automatic drive(
    input bit           v,
    input logic [127:0] w,
    input bit           c,
    input exp_t         e
  );
    ts_i_vld = v;
    ts_i     = w;
    clr      = c;
    @(posedge clk);
    #1;
    sb.push_back(e);
    ts_i_vld = 1'b0;
    clr      = 1'b0;
  endtask

  logic [127:0] w1, w2, wp, wl, wb;

  initial begin
    rst      = 1'b1;
    ts_i     = '0;
    ts_i_vld = 1'b0;
    clr      = 1'b0;
    w1 = mk(8'h4A, 8'h00, 8'h02, 8'h00);
    w2 = mk(8'h45, 8'h00, 8'h02, 8'h08);
    wp = mk(8'h4A, 8'hF7, 8'hF7, 8'h00);
    wl = mk(8'h4A, 8'h00, 8'h03, 8'h00);
    wb = w1;
    wb[7:0] = 8'hBD;
    #1;
    chk_now("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i <= 8; i++)
      drive(1, w1, 0, ex("ts1_run", i, 1, i >= 8,
                         8'h00, 8'h02, 8'h00, 0));
    drive(0, '0, 1, z("clr_idle"));

    for (int i = 1; i <= 7; i++)
      drive(1, w1, 0, ex("ts1_pre", i, 1, 0,
                         8'h00, 8'h02, 8'h00, 0));
    drive(1, w2, 0, ex("ts2_switch", 1, 2, 0,
                       8'h00, 8'h02, 8'h08, 0));
    for (int i = 2; i <= 8; i++)
      drive(1, w2, 0, ex("ts2_run", i, 2, i >= 8,
                         8'h00, 8'h02, 8'h08, 0));

    drive(1, w1, 0, ex("back_ts1", 1, 1, 0,
                       8'h00, 8'h02, 8'h00, 0));
    drive(1, w1, 0, ex("back_ts1", 2, 1, 0,
                       8'h00, 8'h02, 8'h00, 0));
    drive(1, wl, 0, ex("lane_chg", 1, 1, 0,
                       8'h00, 8'h03, 8'h00, 0));
    drive(0, '0, 1, z("clr2"));

    for (int i = 1; i <= 5; i++)
      drive(1, w1, 0, ex("pre_err", i, 1, 0,
                         8'h00, 8'h02, 8'h00, 0));
    drive(1, wb, 0, ex("bad_com", 0, 0, 0,
                       8'h00, 8'h00, 8'h00, 1));
    drive(0, '0, 0, z("err_pulse_end"));

    for (int i = 1; i <= 8; i++)
      drive(1, wp, 0, ex("pad_run", i, 1, i >= 8,
                         8'hF7, 8'hF7, 8'h00, 0));
    for (int i = 1; i <= 63; i++)
      drive(0, '0, 0, ex("gap_hold", 8, 1, 1,
                         8'hF7, 8'hF7, 8'h00, 0));
    drive(0, '0, 0, z("gap_timeout"));

    for (int i = 1; i <= 7; i++)
      drive(1, w1, 0, ex("pre_clr", i, 1, 0,
                         8'h00, 8'h02, 8'h00, 0));
    drive(1, w1, 1, z("clr_with_word"));
    drive(0, '0, 0, z("after_clr"));

    for (int i = 1; i <= 20; i++)
      drive(1, w1, 0, ex("sat_run", i > 15 ? 15 : i, 1,
                         i >= 8, 8'h00, 8'h02, 8'h00, 0));
    @(negedge clk);
    #1;
    ts_i_vld = 1'b1;
    ts_i     = w1;
    rst      = 1'b1;
    #1;
    chk_now("async_rst");
    @(negedge clk);
    rst      = 1'b0;
    ts_i_vld = 1'b0;
    drive(0, '0, 0, z("post_rst"));

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
